serdes_rx_aligner: RTL
======================

Name: serdes_rx_aligner

Overview:
- Receive-side word aligner on the parallel side of an ISERDESE2 in NETWORKING mode.
- Watches deserialized words for a fixed training pattern and issues single-cycle BITSLIP pulses until the word boundary locks.
- Once locked, passes data through and counts pattern errors while checking is enabled.
- Closes the link loop opposite the OSERDESE2 transmitter that sends the training pattern.

Parameters:
- DATA_WIDTH, 8: ISERDES parallel word width. Legal values 4..8.
- TRAIN_PATTERN, 8'hB8: training word in the low DATA_WIDTH bits. It must have no rotational symmetry across DATA_WIDTH rotations.
- SLIP_WAIT, 3: CLKDIV cycles to ignore after each BITSLIP pulse, covering ISERDES BITSLIP latency. Minimum 2.
- MATCH_COUNT, 16: consecutive matching words needed to declare lock. Minimum 1.

Ports:
- CLKDIV  in  1  parallel-side clock; all logic runs on its rising edge.
- RST  in  1  synchronous, active-high reset; clock CLKDIV.
- RETRAIN  in  1  single-cycle request to restart alignment.
- DATA_IN  in  DATA_WIDTH  word from ISERDES Q outputs.
- CHECK_EN  in  1  enables pattern error counting while LOCKED.
- BITSLIP  out  1  pulse to ISERDES BITSLIP.
- LOCKED  out  1  word alignment achieved.
- FAIL  out  1  all alignments tried without lock.
- SLIP_CNT  out  $clog2(DATA_WIDTH)  number of BITSLIP pulses issued in the current attempt.
- DATA_OUT  out  DATA_WIDTH  registered copy of DATA_IN.
- DATA_VALID  out  1  DATA_OUT is aligned data.
- ERR_CNT  out  16  saturating count of mismatches while LOCKED and CHECK_EN.

Behaviour:
- Reset: state SETTLE, all internal counters 0. BITSLIP, LOCKED, FAIL and DATA_VALID are 0; SLIP_CNT, ERR_CNT and DATA_OUT are 0.
- Priority: RST > RETRAIN > normal transitions.
- RETRAIN in any state: next state SETTLE. Clears the wait counter, match counter, SLIP_CNT and ERR_CNT. Drops LOCKED, FAIL and DATA_VALID on the next edge.
- All outputs are registered.
- SETTLE:
  - Wait counter runs 0..SLIP_WAIT-1; DATA_IN is ignored.
  - On terminal count, go to COMPARE with the match counter at 0.
- COMPARE, one word per cycle:
  - DATA_IN == TRAIN_PATTERN: match counter increments. When the match is the MATCH_COUNT-th consecutive one, go to LOCKED.
  - Mismatch: match counter clears. If SLIP_CNT == DATA_WIDTH-1, go to FAIL; otherwise go to SLIP.
- SLIP:
  - BITSLIP = 1 for exactly this one cycle.
  - SLIP_CNT increments.
  - Next state SETTLE.
  - BITSLIP is never asserted in two consecutive cycles, nor within SLIP_WAIT cycles of the previous pulse.
- LOCKED:
  - LOCKED = 1 and DATA_VALID = 1, starting on the cycle after the final match.
  - DATA_OUT = DATA_IN, delayed one cycle.
  - If CHECK_EN and DATA_IN != TRAIN_PATTERN, ERR_CNT increments, saturating at 16'hFFFF.
  - Stays in LOCKED until RST or RETRAIN; mismatches never unlock.
- FAIL: FAIL = 1 and BITSLIP = 0. Holds until RST or RETRAIN.
- DATA_OUT updates every cycle in every state, but DATA_VALID is 1 only in LOCKED.
- Lock latency from reset with aligned data: SLIP_WAIT + MATCH_COUNT cycles to the entry edge, with LOCKED visible one cycle later.
- Each slip adds 1 + SLIP_WAIT cycles, plus the cycles spent comparing before the mismatch.
- Comparison uses only DATA_IN[DATA_WIDTH-1:0] against TRAIN_PATTERN[DATA_WIDTH-1:0].

Decomposition:
- Package serdes_pkg holds:
  - state enum {SETTLE, COMPARE, SLIP, LOCKED, FAIL}
  - ERR_CNT_W = 16
  - default TRAIN_PATTERN constant
- No RTL sub-module; a single FSM plus counters.
- The bench provides an ISERDES bitslip model that rotates the word one bit per BITSLIP pulse, with 2-cycle latency.

Test Plan:
- Aligned stream of 8'hB8 after RST release -> 0 BITSLIP pulses. FSM enters LOCKED after 19 cycles (SLIP_WAIT 3 + MATCH_COUNT 16); LOCKED and DATA_VALID are visible on cycle 20; SLIP_CNT = 0.
- Stream rotated by 5 bits -> exactly 5 BITSLIP pulses, each at least 4 cycles apart. Then LOCKED = 1 and SLIP_CNT = 5.
- Constant 8'h00 input -> 7 pulses, then FAIL = 1 and LOCKED = 0, with no further BITSLIP. A RETRAIN pulse clears FAIL and SLIP_CNT on the next cycle.
- Aligned stream with one corrupted word at match 10 -> match counter restarts and 1 BITSLIP is issued. A bench that undoes the slip (rotates back) sees lock within 8 further slips.
- LOCKED with CHECK_EN = 1 and 3 bad words -> ERR_CNT = 3. With CHECK_EN = 0 and bad words -> ERR_CNT unchanged. Forcing the count to 16'hFFFE and injecting 3 errors -> saturates at 16'hFFFF.
- RST asserted in SLIP and in LOCKED, and RST together with RETRAIN -> all outputs return to reset values on the next edge, and the full alignment sequence repeats.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared types and constants for the ISERDES receive word aligner.
package serdes_pkg;

  typedef enum logic [2:0] {
    SETTLE,
    COMPARE,
    SLIP,
    LOCKED,
    FAIL
  } state_t;

  localparam int         ERR_CNT_W         = 16;
  localparam logic [7:0] TRAIN_PATTERN_DEF = 8'hB8;

endpackage

// File: rtl/serdes_rx_aligner_if.sv
// Aligner-to-PHY signal bundle; master is the aligner, slave is the ISERDES/link side.
interface serdes_rx_aligner_if #(
  parameter int DATA_WIDTH = 8
);

  logic                              RETRAIN;
  logic                              CHECK_EN;
  logic [DATA_WIDTH-1:0]             DATA_IN;
  logic                              BITSLIP;
  logic                              LOCKED;
  logic                              FAIL;
  logic [$clog2(DATA_WIDTH)-1:0]     SLIP_CNT;
  logic [DATA_WIDTH-1:0]             DATA_OUT;
  logic                              DATA_VALID;
  logic [serdes_pkg::ERR_CNT_W-1:0]  ERR_CNT;

  modport master (
    input  RETRAIN, CHECK_EN, DATA_IN,
    output BITSLIP, LOCKED, FAIL, SLIP_CNT, DATA_OUT, DATA_VALID, ERR_CNT
  );

  modport slave (
    output RETRAIN, CHECK_EN, DATA_IN,
    input  BITSLIP, LOCKED, FAIL, SLIP_CNT, DATA_OUT, DATA_VALID, ERR_CNT
  );

endinterface

// File: rtl/serdes_rx_aligner.sv
// Word aligner: slips the ISERDES boundary until TRAIN_PATTERN repeats MATCH_COUNT times, then passes data.
// Latency: DATA_OUT is DATA_IN delayed one CLKDIV; no backpressure, BITSLIP is a fire-and-forget pulse.
module serdes_rx_aligner
  import serdes_pkg::*;
#(
  parameter int         DATA_WIDTH    = 8,
  parameter logic [7:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
  parameter int         SLIP_WAIT     = 3,
  parameter int         MATCH_COUNT   = 16
) (
  input  logic                CLKDIV,
  input  logic                RST,
  serdes_rx_aligner_if.master bus
);

  localparam int SLIP_W  = $clog2(DATA_WIDTH);
  localparam int WAIT_W  = $clog2(SLIP_WAIT);
  localparam int MATCH_W = $clog2(MATCH_COUNT + 1);

  localparam logic [DATA_WIDTH-1:0] PATTERN    = TRAIN_PATTERN[DATA_WIDTH-1:0];
  localparam logic [WAIT_W-1:0]     WAIT_LAST  = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [MATCH_W-1:0]    MATCH_LAST = MATCH_W'(MATCH_COUNT - 1);
  localparam logic [SLIP_W-1:0]     SLIP_LAST  = SLIP_W'(DATA_WIDTH - 1);

  state_t                  state, state_n;
  logic [WAIT_W-1:0]       wait_cnt, wait_n;
  logic [MATCH_W-1:0]      match_cnt, match_n;
  logic [SLIP_W-1:0]       slip_cnt, slip_n;
  logic [ERR_CNT_W-1:0]    err_cnt, err_n;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    bitslip_q, locked_q, fail_q, valid_q;
  logic                    is_match;

  assign is_match = (bus.DATA_IN == PATTERN);

  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    match_n = match_cnt;
    slip_n  = slip_cnt;
    err_n   = err_cnt;

    case (state)
      SETTLE: begin
        if (wait_cnt == WAIT_LAST) begin
          wait_n  = '0;
          match_n = '0;
          state_n = COMPARE;
        end else begin
          wait_n = wait_cnt + WAIT_W'(1);
        end
      end
      COMPARE: begin
        if (is_match) begin
          match_n = match_cnt + MATCH_W'(1);
          if (match_cnt == MATCH_LAST) state_n = LOCKED;
        end else begin
          match_n = '0;
          state_n = (slip_cnt == SLIP_LAST) ? FAIL : SLIP;
        end
      end
      SLIP: begin
        slip_n  = slip_cnt + SLIP_W'(1);
        state_n = SETTLE;
      end
      LOCKED: begin
        // Mismatches are counted only; a locked link never falls back to training on its own.
        if (bus.CHECK_EN && !is_match && (err_cnt != '1))
          err_n = err_cnt + ERR_CNT_W'(1);
      end
      FAIL:    state_n = FAIL;
      default: state_n = SETTLE;
    endcase

    if (bus.RETRAIN) begin
      state_n = SETTLE;
      wait_n  = '0;
      match_n = '0;
      slip_n  = '0;
      err_n   = '0;
    end
  end

  // Flags are decoded from the next state so every output is a flop.
  always_ff @(posedge CLKDIV) begin
    if (RST) begin
      state     <= SETTLE;
      wait_cnt  <= '0;
      match_cnt <= '0;
      slip_cnt  <= '0;
      err_cnt   <= '0;
      data_q    <= '0;
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_n;
      match_cnt <= match_n;
      slip_cnt  <= slip_n;
      err_cnt   <= err_n;
      data_q    <= bus.DATA_IN;
      bitslip_q <= (state_n == SLIP);
      locked_q  <= (state_n == LOCKED);
      fail_q    <= (state_n == FAIL);
      valid_q   <= (state_n == LOCKED);
    end
  end

  assign bus.BITSLIP    = bitslip_q;
  assign bus.LOCKED     = locked_q;
  assign bus.FAIL       = fail_q;
  assign bus.SLIP_CNT   = slip_cnt;
  assign bus.DATA_OUT   = data_q;
  assign bus.DATA_VALID = valid_q;
  assign bus.ERR_CNT    = err_cnt;

endmodule
